latch_vector_driver: RTL and testbench

Self-checking stimulus sequencer that drives the enable-gated latch function block (`y` latched from `(a & b | hidden) ^ flip` while `en` is high) and checks its response. It walks a fixed seven-vector sequence, waits a programmable settle interval per vector, samples the block's `y` with 4-state exact comparison, and reports a fail count, the first failing vector and a final pass flag. It sits beside the latch block in the regression harness as the driving and checking end of its `a/b/hidden/flip/en -> y` interface.

---
 rtl/latch_vector_driver.sv | 157 +++++++++++++++
 tb/tb_latch_vector_driver.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/latch_vector_driver.sv
// Stimulus sequencer and checker for the enable-gated latch block: walks seven
// fixed vectors, samples y after a settle interval and records the verdict.
module latch_vector_driver #(
    parameter int unsigned SETTLE = 4,
    parameter logic        FLIP   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dut_y,
    output logic       a,
    output logic       b,
    output logic       hidden,
    output logic       en,
    output logic       flip,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] fail_count,
    output logic [2:0] fail_index
);

    localparam int unsigned CNT_W    = 8;
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned FC_W     = 3;
    localparam int unsigned STIM_W   = 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(6);
    localparam logic [IDX_W-1:0] NO_FAIL  = IDX_W'(7);
    localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(SETTLE - 1);
    // Expected y per vector before FLIP; bit k belongs to vector k.
    localparam logic [7:0] EXP_RAW = 8'b0110_1000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [STIM_W-1:0]   stim_q, stim_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [FC_W-1:0]     fc_q, fc_d;
    logic [IDX_W-1:0]    fi_q, fi_d;
    logic                exp_c;
    logic                fail_c;
    logic [FC_W-1:0]     fc_next_c;

    // Vector table packed as {en, hidden, a, b}.
    function automatic logic [STIM_W-1:0] vec_of(input logic [IDX_W-1:0] idx);
        case (idx)
            3'd0:    vec_of = 4'b1000;
            3'd1:    vec_of = 4'b1001;
            3'd2:    vec_of = 4'b1010;
            3'd3:    vec_of = 4'b1011;
            3'd4:    vec_of = 4'b1000;
            3'd5:    vec_of = 4'b1100;
            default: vec_of = 4'b0000;
        endcase
    endfunction

    assign exp_c     = EXP_RAW[idx_q] ^ FLIP;
    // Exact match so an X or Z on dut_y counts as a failure.
    assign fail_c    = (dut_y !== exp_c);
    assign fc_next_c = fc_q + FC_W'(fail_c);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            stim_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fc_q    <= '0;
            fi_q    <= NO_FAIL;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            stim_q  <= stim_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fc_q    <= fc_d;
            fi_q    <= fi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_RUN;
            S_RUN:          if (cnt_q == '0 && idx_q == LAST_IDX) state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        stim_d = stim_q;
        busy_d = busy_q;
        done_d = done_q;
        pass_d = pass_q;
        fc_d   = fc_q;
        fi_d   = fi_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    idx_d  = '0;
                    cnt_d  = RELOAD;
                    stim_d = vec_of(IDX_W'(0));
                    busy_d = 1'b1;
                    done_d = 1'b0;
                    pass_d = 1'b0;
                    fc_d   = '0;
                    fi_d   = NO_FAIL;
                end
            end
            S_RUN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    fc_d = fc_next_c;
                    if (fail_c && fi_q == NO_FAIL) fi_d = idx_q;
                    if (idx_q != LAST_IDX) begin
                        idx_d  = idx_q + IDX_W'(1);
                        stim_d = vec_of(idx_q + IDX_W'(1));
                        cnt_d  = RELOAD;
                    end else begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                        pass_d = (fc_next_c == '0);
                    end
                end
            end
            default: ;
        endcase
    end

    assign en         = stim_q[3];
    assign hidden     = stim_q[2];
    assign a          = stim_q[1];
    assign b          = stim_q[0];
    assign flip       = FLIP;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail_count = fc_q;
    assign fail_index = fi_q;

endmodule

// File: tb/tb_latch_vector_driver.sv
// Bench for latch_vector_driver: three instances (SETTLE/FLIP variants) each
// facing a behavioural latch model, with run verdicts checked via a scoreboard.
module tb_latch_vector_driver;

    typedef struct {
        int          u;
        int          lat;
        logic        pass;
        logic [2:0]  fc;
        logic [2:0]  fi;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [2:0] start_w, y_w, a_w, b_w, h_w, en_w, flip_w, busy_w, done_w, pass_w;
    logic [2:0] fc_w [3];
    logic [2:0] fi_w [3];
    logic       lat0, lat2, x_bad;
    int         mode0;
    int         checks, failures;
    exp_t       sb[$];

    latch_vector_driver #(.SETTLE(4), .FLIP(1'b0)) u0 (
        .clk(clk), .rst(rst), .start(start_w[0]), .dut_y(y_w[0]),
        .a(a_w[0]), .b(b_w[0]), .hidden(h_w[0]), .en(en_w[0]), .flip(flip_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .fail_count(fc_w[0]), .fail_index(fi_w[0]));

    latch_vector_driver #(.SETTLE(4), .FLIP(1'b1)) u1 (
        .clk(clk), .rst(rst), .start(start_w[1]), .dut_y(y_w[1]),
        .a(a_w[1]), .b(b_w[1]), .hidden(h_w[1]), .en(en_w[1]), .flip(flip_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .fail_count(fc_w[1]), .fail_index(fi_w[1]));

    latch_vector_driver #(.SETTLE(1), .FLIP(1'b0)) u2 (
        .clk(clk), .rst(rst), .start(start_w[2]), .dut_y(y_w[2]),
        .a(a_w[2]), .b(b_w[2]), .hidden(h_w[2]), .en(en_w[2]), .flip(flip_w[2]),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
        .fail_count(fc_w[2]), .fail_index(fi_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Latch block models; u0 can also be stuck low or go X on vector 1 only.
    always_latch if (en_w[0]) lat0 = (a_w[0] & b_w[0]) | h_w[0];
    always_latch if (en_w[2]) lat2 = (a_w[2] & b_w[2]) | h_w[2];
    assign y_w[0] = (mode0 == 1) ? 1'b0 :
                    (mode0 == 2 && en_w[0] && !a_w[0] && b_w[0] && !h_w[0]) ? x_bad : lat0;
    assign y_w[1] = ((a_w[1] & b_w[1]) | h_w[1]) ^ 1'b1;
    assign y_w[2] = lat2;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered #1 after a rising edge; start is sampled on the next edge (E0).
    task automatic run_unit(input int u, input int poke, output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        start_w[u] = 1'b1;
        @(posedge clk); #1;
        start_w[u] = 1'b0;
        check("busy_after_start", 8'(busy_w[u]), 8'd1);
        check("done_after_start", 8'(done_w[u]), 8'd0);
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            start_w[u] = (n == poke);
            if (done_w[u]) begin
                lat = n;
                ok  = 1'b1;
                break;
            end
        end
        start_w[u] = 1'b0;
    endtask

    task automatic finish_run(input int lat, input bit ok);
        exp_t e;
        e = sb.pop_front();
        check("done_seen", 8'(ok), 8'd1);
        check("latency", 8'(lat), 8'(e.lat));
        check("done", 8'(done_w[e.u]), 8'd1);
        check("busy_end", 8'(busy_w[e.u]), 8'd0);
        check("pass", 8'(pass_w[e.u]), 8'(e.pass));
        check("fail_count", 8'(fc_w[e.u]), 8'(e.fc));
        check("fail_index", 8'(fi_w[e.u]), 8'(e.fi));
        check("en_end", 8'(en_w[e.u]), 8'd0);
    endtask

    task automatic push(input int u, input int lat, input logic p, input logic [2:0] fc,
                        input logic [2:0] fi);
        exp_t e;
        e.u = u; e.lat = lat; e.pass = p; e.fc = fc; e.fi = fi;
        sb.push_back(e);
    endtask

    initial begin
        int lat;
        bit ok;
        checks   = 0;
        failures = 0;
        mode0    = 0;
        start_w  = '0;
        rst      = 1'b1;
        // Two-state simulators collapse X; then use a level that is wrong for v1.
        x_bad = 1'bx;
        if (x_bad === 1'b0 || x_bad === 1'b1) x_bad = 1'b1;

        #12;
        check("rst_busy", 8'(busy_w[0]), 8'd0);
        check("rst_done", 8'(done_w[0]), 8'd0);
        check("rst_pass", 8'(pass_w[0]), 8'd0);
        check("rst_fc", 8'(fc_w[0]), 8'd0);
        check("rst_fi", 8'(fi_w[0]), 8'd7);
        check("rst_stim", 8'({en_w[0], h_w[0], a_w[0], b_w[0]}), 8'd0);
        check("flip0", 8'(flip_w[0]), 8'd0);
        check("flip1", 8'(flip_w[1]), 8'd1);
        check("rst_fi_u1", 8'(fi_w[1]), 8'd7);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        push(0, 28, 1'b1, 3'd0, 3'd7);
        run_unit(0, 0, lat, ok);
        finish_run(lat, ok);

        mode0 = 1;
        push(0, 28, 1'b0, 3'd3, 3'd3);
        run_unit(0, 0, lat, ok);
        finish_run(lat, ok);

        mode0 = 2;
        push(0, 28, 1'b0, 3'd1, 3'd1);
        run_unit(0, 0, lat, ok);
        finish_run(lat, ok);

        push(1, 28, 1'b0, 3'd1, 3'd6);
        run_unit(1, 0, lat, ok);
        finish_run(lat, ok);

        // Abort a run at cycle 10 with an asynchronous reset.
        mode0 = 1;
        start_w[0] = 1'b1;
        @(posedge clk); #1;
        start_w[0] = 1'b0;
        repeat (9) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("abort_busy", 8'(busy_w[0]), 8'd0);
        check("abort_done", 8'(done_w[0]), 8'd0);
        check("abort_pass", 8'(pass_w[0]), 8'd0);
        check("abort_fc", 8'(fc_w[0]), 8'd0);
        check("abort_fi", 8'(fi_w[0]), 8'd7);
        check("abort_stim", 8'({en_w[0], h_w[0], a_w[0], b_w[0]}), 8'd0);
        #1 rst = 1'b0;
        mode0 = 0;
        @(posedge clk); #1;
        check("idle_after_rst", 8'(busy_w[0]), 8'd0);
        push(0, 28, 1'b1, 3'd0, 3'd7);
        run_unit(0, 0, lat, ok);
        finish_run(lat, ok);

        // SETTLE=1: start during RUN is ignored, then restart straight from DONE.
        push(2, 7, 1'b1, 3'd0, 3'd7);
        run_unit(2, 3, lat, ok);
        finish_run(lat, ok);
        push(2, 7, 1'b1, 3'd0, 3'd7);
        run_unit(2, 0, lat, ok);
        finish_run(lat, ok);

        check("sb_empty", 8'(sb.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
